tiny_fft_stream: RTL and testbench

//  Parametrised successor to the fixed 4-point tiny FFT. Accepts a frame of N real samples,

---
 rtl/tiny_fft_stream.sv | 228 ++++++++++++++++++++++
 tb/tb_tiny_fft_stream.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tiny_fft_stream.sv
`default_nettype none
// ============================================================================
// Module   : tiny_fft_stream
// Purpose  : Frame-based N-point (4 or 8) radix-2 DIT FFT/IFFT on real
//            samples. Samples are loaded into a bit-reversed working memory.
//            One shared butterfly runs (N/2)*log2(N) cycles in place. The
//            complex bins are then streamed out in natural order under a
//            valid/ready handshake.
// Ports    : clk, rst_n            - clock, asynchronous active-low reset
//            wr_en, data_in, inv   - sample input (inv taken with sample 0)
//            wr_ready, busy        - LOAD / (COMPUTE or OUTPUT) status
//            out_valid, out_ready  - output handshake
//            out_re, out_im        - signed bin value, OUT_W bits
//            out_idx, out_first    - bin index, first-bin marker
//            overrun               - sticky: write attempted while not ready
// Revision : 1.0 - initial release
// ============================================================================
module tiny_fft_stream #(
    parameter int N_POINTS  = 4,
    parameter int DATA_W    = 4,
    parameter int SIGNED_IN = 0,
    localparam int LOGN     = (N_POINTS == 8) ? 3 : 2,
    localparam int OUT_W    = DATA_W + LOGN + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [DATA_W-1:0]       data_in,
    input  logic                    inv,
    output logic                    wr_ready,
    output logic                    busy,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_re,
    output logic signed [OUT_W-1:0] out_im,
    output logic [LOGN-1:0]         out_idx,
    output logic                    out_first,
    output logic                    overrun
);

    generate
        if (N_POINTS != 4 && N_POINTS != 8) begin : g_bad_n_points
            $error("tiny_fft_stream: N_POINTS must be 4 or 8");
        end
    endgenerate

    localparam int                   BW       = LOGN - 1;
    localparam int                   PW       = OUT_W + 10;
    localparam logic [LOGN-1:0]      LAST_IDX = LOGN'(N_POINTS - 1);
    localparam logic signed [PW-1:0] COEF     = PW'(181);   // cos(pi/4) in Q8

    typedef enum logic [1:0] {
        S_LOAD    = 2'd0,
        S_COMPUTE = 2'd1,
        S_OUTPUT  = 2'd2
    } state_t;

    state_t state, state_next;

    logic signed [OUT_W-1:0] mem_re [N_POINTS];
    logic signed [OUT_W-1:0] mem_im [N_POINTS];

    logic [LOGN-1:0] samp_cnt;
    logic [BW-1:0]   bf_cnt;
    logic [1:0]      stage;
    logic            inv_q;
    logic            accept;
    logic            comp_last;
    logic [LOGN-1:0] next_idx;
    logic signed [OUT_W-1:0] ext_sample;

    function automatic logic [LOGN-1:0] bit_rev(input logic [LOGN-1:0] v);
        for (int i = 0; i < LOGN; i++) begin
            bit_rev[i] = v[LOGN-1-i];
        end
    endfunction

    assign accept    = wr_en && wr_ready;
    assign comp_last = (state == S_COMPUTE) && (&bf_cnt) && (stage == 2'(LOGN - 1));
    assign next_idx  = out_idx + LOGN'(1);
    assign out_first = out_valid && (out_idx == '0);

    always_comb begin
        if (SIGNED_IN != 0) begin
            ext_sample = {{(OUT_W-DATA_W){data_in[DATA_W-1]}}, data_in};
        end else begin
            ext_sample = {{(OUT_W-DATA_W){1'b0}}, data_in};
        end
    end

    // Butterfly addressing: butterfly j of a stage with span 'half' lives in
    // group j/half at offset j%half; its twiddle exponent is offset scaled
    // to N. tw is that exponent expressed in eighths of a turn.
    logic [LOGN-1:0] j_ext, half, low_mask, pos, addr_a, addr_b, tw_n;
    logic [1:0]      tw;

    always_comb begin
        j_ext    = {1'b0, bf_cnt};
        half     = LOGN'(1) << stage;
        low_mask = half - LOGN'(1);
        pos      = j_ext & low_mask;
        addr_a   = ((j_ext & ~low_mask) << 1) | pos;
        addr_b   = addr_a | half;
        tw_n     = pos << (2'(LOGN - 1) - stage);
        tw       = 2'(tw_n << (3 - LOGN));
    end

    // W*b: trivial twiddles are exact. The odd eighth-turn twiddles use
    // c = s = 181/256 and one floor shift of the full-precision sum.
    logic signed [OUT_W-1:0] a_re, a_im, b_re, b_im, wb_re, wb_im;
    logic signed [PW-1:0]    br_x, bi_x, pr, pi, sum_re, sum_im;

    always_comb begin
        a_re   = mem_re[addr_a];
        a_im   = mem_im[addr_a];
        b_re   = mem_re[addr_b];
        b_im   = mem_im[addr_b];
        br_x   = PW'(b_re);
        bi_x   = PW'(b_im);
        pr     = br_x * COEF;
        pi     = bi_x * COEF;
        sum_re = '0;
        sum_im = '0;
        wb_re  = b_re;
        wb_im  = b_im;
        case (tw)
            2'd1: begin
                sum_re = inv_q ? (pr - pi) : (pr + pi);
                sum_im = inv_q ? (pi + pr) : (pi - pr);
                wb_re  = OUT_W'(sum_re >>> 8);
                wb_im  = OUT_W'(sum_im >>> 8);
            end
            2'd2: begin
                wb_re = inv_q ? -b_im : b_im;
                wb_im = inv_q ? b_re  : -b_re;
            end
            2'd3: begin
                sum_re = inv_q ? (-pr - pi) : (pi - pr);
                sum_im = inv_q ? (pr - pi)  : (-pi - pr);
                wb_re  = OUT_W'(sum_re >>> 8);
                wb_im  = OUT_W'(sum_im >>> 8);
            end
            default: ;
        endcase
    end

    always_comb begin
        state_next = state;
        wr_ready   = 1'b0;
        busy       = 1'b0;
        case (state)
            S_LOAD: begin
                wr_ready = 1'b1;
                if (accept && samp_cnt == LAST_IDX) state_next = S_COMPUTE;
            end
            S_COMPUTE: begin
                busy = 1'b1;
                if (comp_last) state_next = S_OUTPUT;
            end
            S_OUTPUT: begin
                busy = 1'b1;
                if (out_valid && out_ready && out_idx == LAST_IDX) state_next = S_LOAD;
            end
            default: state_next = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_LOAD;
            samp_cnt  <= '0;
            bf_cnt    <= '0;
            stage     <= '0;
            inv_q     <= 1'b0;
            overrun   <= 1'b0;
            out_valid <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
            out_idx   <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                samp_cnt <= samp_cnt + LOGN'(1);
                if (samp_cnt == '0) begin
                    inv_q   <= inv;
                    overrun <= 1'b0;
                end
            end
            if (wr_en && !wr_ready) overrun <= 1'b1;
            if (state == S_COMPUTE) begin
                bf_cnt <= bf_cnt + BW'(1);
                if (&bf_cnt) stage <= comp_last ? 2'd0 : stage + 2'd1;
            end
            if (state == S_OUTPUT) begin
                // First OUTPUT cycle primes the output register with bin 0.
                if (!out_valid) begin
                    out_valid <= 1'b1;
                    out_idx   <= '0;
                    out_re    <= mem_re[0];
                    out_im    <= mem_im[0];
                end else if (out_ready) begin
                    if (out_idx == LAST_IDX) begin
                        out_valid <= 1'b0;
                    end else begin
                        out_idx <= next_idx;
                        out_re  <= mem_re[next_idx];
                        out_im  <= mem_im[next_idx];
                    end
                end
            end
        end
    end

    // Working memory: contents are don't-care after reset, so no reset term.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_re[bit_rev(samp_cnt)] <= ext_sample;
            mem_im[bit_rev(samp_cnt)] <= '0;
        end else if (state == S_COMPUTE) begin
            mem_re[addr_a] <= a_re + wb_re;
            mem_im[addr_a] <= a_im + wb_im;
            mem_re[addr_b] <= a_re - wb_re;
            mem_im[addr_b] <= a_im - wb_im;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tiny_fft_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_tiny_fft_stream
// Purpose  : Directed self-checking bench for tiny_fft_stream. Three
//            instances (N=4 unsigned, N=4 signed, N=8 unsigned) share clock,
//            reset and data; 'sel' picks which one is written and observed.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tiny_fft_stream;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_drv = 1'b0;
    logic [3:0] data_in = '0;
    logic       inv = 1'b0;
    logic       out_ready = 1'b0;
    int         sel = 0;

    always #5 clk = ~clk;

    logic wr4, wr4s, wr8;
    assign wr4  = wr_drv && (sel == 0);
    assign wr4s = wr_drv && (sel == 1);
    assign wr8  = wr_drv && (sel == 2);

    logic rdy4, busy4, ov4, first4, orun4;
    logic signed [6:0] re4, im4;
    logic [1:0] idx4;
    logic rdy4s, busy4s, ov4s, first4s, orun4s;
    logic signed [6:0] re4s, im4s;
    logic [1:0] idx4s;
    logic rdy8, busy8, ov8, first8, orun8;
    logic signed [7:0] re8, im8;
    logic [2:0] idx8;

    tiny_fft_stream #(.N_POINTS(4), .DATA_W(4), .SIGNED_IN(0)) dut4 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr4), .data_in(data_in), .inv(inv),
        .wr_ready(rdy4), .busy(busy4), .out_valid(ov4), .out_ready(out_ready),
        .out_re(re4), .out_im(im4), .out_idx(idx4), .out_first(first4), .overrun(orun4));

    tiny_fft_stream #(.N_POINTS(4), .DATA_W(4), .SIGNED_IN(1)) dut4s (
        .clk(clk), .rst_n(rst_n), .wr_en(wr4s), .data_in(data_in), .inv(inv),
        .wr_ready(rdy4s), .busy(busy4s), .out_valid(ov4s), .out_ready(out_ready),
        .out_re(re4s), .out_im(im4s), .out_idx(idx4s), .out_first(first4s), .overrun(orun4s));

    tiny_fft_stream #(.N_POINTS(8), .DATA_W(4), .SIGNED_IN(0)) dut8 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr8), .data_in(data_in), .inv(inv),
        .wr_ready(rdy8), .busy(busy8), .out_valid(ov8), .out_ready(out_ready),
        .out_re(re8), .out_im(im8), .out_idx(idx8), .out_first(first8), .overrun(orun8));

    logic              mon_valid, mon_first, mon_wr_ready, mon_busy, mon_overrun;
    logic signed [7:0] mon_re, mon_im;
    logic [2:0]        mon_idx;

    always_comb begin
        mon_valid = 1'b0; mon_first = 1'b0; mon_wr_ready = 1'b0; mon_busy = 1'b0;
        mon_overrun = 1'b0; mon_re = '0; mon_im = '0; mon_idx = '0;
        case (sel)
            0: begin
                mon_valid = ov4; mon_first = first4; mon_wr_ready = rdy4; mon_busy = busy4;
                mon_overrun = orun4; mon_re = {re4[6], re4}; mon_im = {im4[6], im4};
                mon_idx = {1'b0, idx4};
            end
            1: begin
                mon_valid = ov4s; mon_first = first4s; mon_wr_ready = rdy4s; mon_busy = busy4s;
                mon_overrun = orun4s; mon_re = {re4s[6], re4s}; mon_im = {im4s[6], im4s};
                mon_idx = {1'b0, idx4s};
            end
            default: begin
                mon_valid = ov8; mon_first = first8; mon_wr_ready = rdy8; mon_busy = busy8;
                mon_overrun = orun8; mon_re = re8; mon_im = im8; mon_idx = idx8;
            end
        endcase
    end

    int   checks = 0;
    int   failures = 0;
    logic [3:0] smp [8];
    int   exp_re [8];
    int   exp_im [8];
    int   got_re [8];
    int   got_im [8];
    int   got_idx [8];
    logic got_first [8];
    int   got_n;

    task automatic load_frame(input int n, input logic inv_v);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            wr_drv  = 1'b1;
            data_in = smp[k];
            inv     = (k == 0) ? inv_v : !inv_v;   // only sample 0 may matter
        end
        @(negedge clk);
        wr_drv = 1'b0;
        inv    = 1'b0;
    endtask

    // Gathers bins with out_ready held high; no comparisons here.
    task automatic collect(input int n);
        int guard = 0;
        for (int i = 0; i < 8; i++) begin
            got_re[i] = 999; got_im[i] = 999; got_idx[i] = 99; got_first[i] = 1'bx;
        end
        got_n = 0;
        out_ready = 1'b1;
        while (got_n < n && guard < 200) begin
            if (mon_valid) begin
                got_re[got_n]    = int'(mon_re);
                got_im[got_n]    = int'(mon_im);
                got_idx[got_n]   = int'(mon_idx);
                got_first[got_n] = mon_first;
                got_n++;
            end
            @(negedge clk);
            guard++;
        end
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; wr_drv = 1'b0; out_ready = 1'b0; inv = 1'b0; data_in = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        sel = 0;
        do_reset();
        checks++;
        if (mon_wr_ready !== 1'b1 || mon_busy !== 1'b0 || mon_valid !== 1'b0 || mon_overrun !== 1'b0) begin
            failures++;
            $display("FAIL reset_status: wr_ready=%b busy=%b valid=%b overrun=%b, required 1 0 0 0",
                     mon_wr_ready, mon_busy, mon_valid, mon_overrun);
        end
        checks++;
        if (mon_re !== 8'sd0 || mon_im !== 8'sd0 || mon_idx !== 3'd0 || mon_first !== 1'b0) begin
            failures++;
            $display("FAIL reset_data: re=%0d im=%0d idx=%0d first=%b, required 0 0 0 0",
                     mon_re, mon_im, mon_idx, mon_first);
        end
    endtask

    task automatic test_dc_latency();
        int cnt = 0;
        sel = 0;
        for (int k = 0; k < 4; k++) smp[k] = 4'd1;
        load_frame(4, 1'b0);
        checks++;
        if (mon_busy !== 1'b1 || mon_wr_ready !== 1'b0) begin
            failures++;
            $display("FAIL dc_busy: busy=%b wr_ready=%b, required 1 0", mon_busy, mon_wr_ready);
        end
        while (!mon_valid && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        checks++;
        if (cnt !== 5) begin
            failures++;
            $display("FAIL dc_latency: cycles=%0d, required 5", cnt);
        end
        collect(4);
        exp_re = '{4, 0, 0, 0, 0, 0, 0, 0};
        exp_im = '{0, 0, 0, 0, 0, 0, 0, 0};
        checks++;
        if (got_n !== 4) begin
            failures++;
            $display("FAIL dc_count: bins=%0d, required 4", got_n);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_re[i] !== exp_re[i] || got_im[i] !== exp_im[i] || got_idx[i] !== i
                || got_first[i] !== (i == 0)) begin
                failures++;
                $display("FAIL dc_bin%0d: re=%0d im=%0d idx=%0d first=%b, required re=%0d im=%0d idx=%0d first=%0d",
                         i, got_re[i], got_im[i], got_idx[i], got_first[i], exp_re[i], exp_im[i], i, (i == 0));
            end
        end
        checks++;
        if (mon_wr_ready !== 1'b1 || mon_busy !== 1'b0 || mon_valid !== 1'b0) begin
            failures++;
            $display("FAIL dc_return: wr_ready=%b busy=%b valid=%b, required 1 0 0",
                     mon_wr_ready, mon_busy, mon_valid);
        end
    endtask

    task automatic test_impulse();
        sel = 0;
        smp[0] = 4'd0; smp[1] = 4'd1; smp[2] = 4'd0; smp[3] = 4'd0;
        for (int pass = 0; pass < 2; pass++) begin
            load_frame(4, pass == 1);
            collect(4);
            exp_re = '{1, 0, -1, 0, 0, 0, 0, 0};
            if (pass == 0) exp_im = '{0, -1, 0, 1, 0, 0, 0, 0};
            else           exp_im = '{0, 1, 0, -1, 0, 0, 0, 0};
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got_re[i] !== exp_re[i] || got_im[i] !== exp_im[i] || got_idx[i] !== i) begin
                    failures++;
                    $display("FAIL impulse_inv%0d_bin%0d: re=%0d im=%0d idx=%0d, required re=%0d im=%0d idx=%0d",
                             pass, i, got_re[i], got_im[i], got_idx[i], exp_re[i], exp_im[i], i);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        sel = 0;
        for (int k = 0; k < 4; k++) smp[k] = 4'd1;
        load_frame(4, 1'b0);
        wr_drv = 1'b1;                 // ignored write in COMPUTE cycle 1
        @(negedge clk);
        wr_drv = 1'b0;
        checks++;
        if (mon_overrun !== 1'b1) begin
            failures++;
            $display("FAIL midreset_overrun_set: overrun=%b, required 1", mon_overrun);
        end
        rst_n = 1'b0;                  // COMPUTE cycle 2
        #1;
        checks++;
        if (mon_wr_ready !== 1'b1 || mon_busy !== 1'b0 || mon_valid !== 1'b0 || mon_overrun !== 1'b0
            || mon_re !== 8'sd0 || mon_im !== 8'sd0 || mon_idx !== 3'd0) begin
            failures++;
            $display("FAIL midreset_values: rdy=%b busy=%b valid=%b orun=%b re=%0d im=%0d idx=%0d, required 1 0 0 0 0 0 0",
                     mon_wr_ready, mon_busy, mon_valid, mon_overrun, mon_re, mon_im, mon_idx);
        end
        @(negedge clk);
        rst_n = 1'b1;
        smp[0] = 4'd0; smp[1] = 4'd1; smp[2] = 4'd0; smp[3] = 4'd0;
        load_frame(4, 1'b0);
        collect(4);
        exp_re = '{1, 0, -1, 0, 0, 0, 0, 0};
        exp_im = '{0, -1, 0, 1, 0, 0, 0, 0};
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_re[i] !== exp_re[i] || got_im[i] !== exp_im[i] || got_idx[i] !== i) begin
                failures++;
                $display("FAIL midreset_bin%0d: re=%0d im=%0d idx=%0d, required re=%0d im=%0d idx=%0d",
                         i, got_re[i], got_im[i], got_idx[i], exp_re[i], exp_im[i], i);
            end
        end
    endtask

    task automatic test_full_scale();
        sel = 0;
        for (int k = 0; k < 4; k++) smp[k] = 4'd15;
        load_frame(4, 1'b0);
        collect(4);
        exp_re = '{60, 0, 0, 0, 0, 0, 0, 0};
        exp_im = '{0, 0, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_re[i] !== exp_re[i] || got_im[i] !== exp_im[i] || got_idx[i] !== i) begin
                failures++;
                $display("FAIL fullscale_bin%0d: re=%0d im=%0d idx=%0d, required re=%0d im=%0d idx=%0d",
                         i, got_re[i], got_im[i], got_idx[i], exp_re[i], exp_im[i], i);
            end
        end
    endtask

    task automatic test_back_pressure();
        int guard = 0;
        int got = 0;
        int hold_re, hold_im;
        logic stalled = 1'b0;
        sel = 0;
        smp[0] = 4'd1; smp[1] = 4'd2; smp[2] = 4'd3; smp[3] = 4'd4;
        exp_re = '{10, -2, -2, -2, 0, 0, 0, 0};
        exp_im = '{0, 2, 0, -2, 0, 0, 0, 0};
        load_frame(4, 1'b0);
        out_ready = 1'b1;
        while (got < 4 && guard < 200) begin
            if (mon_valid) begin
                if (mon_idx == 3'd2 && !stalled) begin
                    out_ready = 1'b0;
                    wr_drv    = 1'b1;      // write attempt during OUTPUT
                    hold_re   = int'(mon_re);
                    hold_im   = int'(mon_im);
                    for (int c = 0; c < 3; c++) begin
                        @(negedge clk);
                        wr_drv = 1'b0;
                        checks++;
                        if (mon_valid !== 1'b1 || mon_idx !== 3'd2 || int'(mon_re) !== hold_re
                            || int'(mon_im) !== hold_im) begin
                            failures++;
                            $display("FAIL stall_hold%0d: valid=%b idx=%0d re=%0d im=%0d, required 1 2 %0d %0d",
                                     c, mon_valid, mon_idx, mon_re, mon_im, hold_re, hold_im);
                        end
                    end
                    stalled   = 1'b1;
                    out_ready = 1'b1;
                end
                checks++;
                if (int'(mon_idx) !== got || int'(mon_re) !== exp_re[got] || int'(mon_im) !== exp_im[got]) begin
                    failures++;
                    $display("FAIL stall_bin%0d: idx=%0d re=%0d im=%0d, required idx=%0d re=%0d im=%0d",
                             got, mon_idx, mon_re, mon_im, got, exp_re[got], exp_im[got]);
                end
                got++;
            end
            @(negedge clk);
            guard++;
        end
        out_ready = 1'b0;
        checks++;
        if (got !== 4) begin
            failures++;
            $display("FAIL stall_count: bins=%0d, required 4", got);
        end
        checks++;
        if (mon_overrun !== 1'b1) begin
            failures++;
            $display("FAIL overrun_set: overrun=%b, required 1", mon_overrun);
        end
        for (int k = 0; k < 4; k++) smp[k] = 4'd1;
        load_frame(4, 1'b0);
        checks++;
        if (mon_overrun !== 1'b0) begin
            failures++;
            $display("FAIL overrun_clear: overrun=%b, required 0", mon_overrun);
        end
        collect(4);
        exp_re = '{4, 0, 0, 0, 0, 0, 0, 0};
        exp_im = '{0, 0, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_re[i] !== exp_re[i] || got_im[i] !== exp_im[i] || got_idx[i] !== i) begin
                failures++;
                $display("FAIL after_overrun_bin%0d: re=%0d im=%0d idx=%0d, required re=%0d im=%0d idx=%0d",
                         i, got_re[i], got_im[i], got_idx[i], exp_re[i], exp_im[i], i);
            end
        end
    endtask

    task automatic test_signed();
        sel = 1;
        for (int k = 0; k < 4; k++) smp[k] = 4'h8;   // -8
        load_frame(4, 1'b0);
        collect(4);
        exp_re = '{-32, 0, 0, 0, 0, 0, 0, 0};
        exp_im = '{0, 0, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_re[i] !== exp_re[i] || got_im[i] !== exp_im[i] || got_idx[i] !== i) begin
                failures++;
                $display("FAIL signed_bin%0d: re=%0d im=%0d idx=%0d, required re=%0d im=%0d idx=%0d",
                         i, got_re[i], got_im[i], got_idx[i], exp_re[i], exp_im[i], i);
            end
        end
    endtask

    task automatic test_n8();
        sel = 2;
        for (int k = 0; k < 8; k++) smp[k] = 4'd0;
        smp[1] = 4'd8;
        load_frame(8, 1'b0);
        collect(8);
        // 8*W8^k with the Q8 floor on odd k
        exp_re = '{8, 5, 0, -6, -8, -5, 0, 6};
        exp_im = '{0, -6, -8, -6, 0, 6, 8, 6};
        checks++;
        if (got_n !== 8) begin
            failures++;
            $display("FAIL n8_count: bins=%0d, required 8", got_n);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (got_re[i] !== exp_re[i] || got_im[i] !== exp_im[i] || got_idx[i] !== i) begin
                failures++;
                $display("FAIL n8_bin%0d: re=%0d im=%0d idx=%0d, required re=%0d im=%0d idx=%0d",
                         i, got_re[i], got_im[i], got_idx[i], exp_re[i], exp_im[i], i);
            end
        end
    endtask

    initial begin
        test_reset();
        test_dc_latency();
        test_impulse();
        test_reset_mid();
        test_full_scale();
        test_back_pressure();
        test_signed();
        test_n8();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
